// File: rtl/instr_adder_la_pkg.sv
// Shared types and constants for the adder logic-analyser driver.
// State encoding, LA control bit positions, default settle time.
package instr_adder_la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/instr_adder_la_driver_counter.sv
// Down-counter used for the run window and the settle delay.
// Loads a value, decrements on request, flags zero.
module la_window_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign zero_o = (cnt_q == '0);

  // next count: load wins, decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && !zero_o)
      cnt_d = cnt_q - W'(1);
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instr_adder_la_driver.sv
// Drives an instrumented adder through its LA pins:
// load operands, clear, run a window, settle, capture result.
module instr_adder_la_driver
  import instr_adder_la_pkg::*;
#(
  parameter int WIN_W  = 16,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             active,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [WIN_W-1:0] cmd_window,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_sum,
  output logic [31:0]      rsp_count,
  output logic             rsp_err,
  output logic             rsp_abort,
  output logic [31:0]      la_ctrl_out,
  output logic [31:0]      la_a_out,
  output logic [31:0]      la_b_out,
  output logic [31:0]      la_oenb_out,
  input  logic [31:0]      la_count_in,
  input  logic [31:0]      la_sum_in
);

  localparam int SET_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;

  state_e state_q, state_d;

  logic [31:0]      a_q, b_q;
  logic [31:0]      sum_q, count_q;
  logic             err_q, abort_q;
  logic             init_q;
  logic             hs, abort, zero;
  logic             ld, dec;
  logic [WIN_W-1:0] ld_val, win_m1;

  assign hs     = cmd_valid & cmd_ready;
  assign win_m1 = (cmd_window == '0) ? '0
                : cmd_window - WIN_W'(1);
  assign abort  = !active &&
                  (state_q == ST_LOAD ||
                   state_q == ST_RUN  ||
                   state_q == ST_SETTLE);

  // counter control: window on handshake, settle at end of run
  always_comb begin
    ld     = 1'b0;
    ld_val = win_m1;
    dec    = 1'b0;
    if (hs) begin
      ld = 1'b1;
    end else if (state_q == ST_RUN && zero) begin
      ld     = 1'b1;
      ld_val = WIN_W'(SET_M1);
    end else if ((state_q == ST_RUN ||
                  state_q == ST_SETTLE) && !zero) begin
      dec = 1'b1;
    end
  end

  la_window_counter #(
    .W(WIN_W)
  ) u_cnt (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_n),
    .load_i     (ld),
    .load_val_i (ld_val),
    .dec_i      (dec),
    .zero_o     (zero)
  );

  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_RESP;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (hs) state_d = ST_LOAD;
        ST_LOAD:    state_d = ST_RUN;
        ST_RUN:     if (zero) state_d = (SETTLE == 0) ?
                                ST_CAPTURE : ST_SETTLE;
        ST_SETTLE:  if (zero) state_d = ST_CAPTURE;
        ST_CAPTURE: state_d = ST_RESP;
        ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // outputs decoded from state
  always_comb begin
    la_ctrl_out = '0;
    unique case (1'b1)
      state_q == ST_LOAD: la_ctrl_out[CTRL_CLEAR] = 1'b1;
      state_q == ST_RUN:  la_ctrl_out[CTRL_RUN]   = 1'b1;
      default: ;
    endcase
  end

  assign cmd_ready   = init_q && active &&
                       (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign la_a_out    = a_q;
  assign la_b_out    = b_q;
  assign la_oenb_out = '0;
  assign rsp_sum     = sum_q;
  assign rsp_count   = count_q;
  assign rsp_err     = err_q;
  assign rsp_abort   = abort_q;

  // operand latch, response capture, reset-release flag
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      init_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (hs) begin
        a_q <= cmd_a;
        b_q <= cmd_b;
      end
      if (abort) begin
        sum_q   <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
        abort_q <= 1'b1;
      end else if (state_q == ST_CAPTURE) begin
        sum_q   <= la_sum_in;
        count_q <= la_count_in;
        err_q   <= (la_sum_in != a_q + b_q);
        abort_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_adder_la_driver.sv
// Scoreboard bench for instr_adder_la_driver.
// Directed commands; monitor checks responses against a queue.
module tb_instr_adder_la_driver;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        active = 1;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [31:0] cmd_a = 0, cmd_b = 0;
  logic [15:0] cmd_window = 0;
  logic        rsp_valid;
  logic        rsp_ready = 1;
  logic [31:0] rsp_sum, rsp_count;
  logic        rsp_err, rsp_abort;
  logic [31:0] la_ctrl_out, la_a_out, la_b_out, la_oenb_out;
  logic [31:0] la_count_in = 0, la_sum_in = 0;

  instr_adder_la_driver dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .active      (active),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_window  (cmd_window),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_sum     (rsp_sum),
    .rsp_count   (rsp_count),
    .rsp_err     (rsp_err),
    .rsp_abort   (rsp_abort),
    .la_ctrl_out (la_ctrl_out),
    .la_a_out    (la_a_out),
    .la_b_out    (la_b_out),
    .la_oenb_out (la_oenb_out),
    .la_count_in (la_count_in),
    .la_sum_in   (la_sum_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] cnt;
    logic        err;
    logic        abt;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hs_edge = 0;
  int   run_hi = 0;
  bit   first = 1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (la_ctrl_out[0]) run_hi++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, req);
    end
  endtask

  // monitor: compare every response cycle to the queue head
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = q[0];
        if (first) begin
          first = 0;
          if (e.lat != 0)
            chk("latency", cyc - hs_edge, e.lat);
        end
        chk("rsp_sum", rsp_sum, e.sum);
        chk("rsp_count", rsp_count, e.cnt);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_abort", {31'b0, rsp_abort}, {31'b0, e.abt});
        if (rsp_ready) begin
          void'(q.pop_front());
          first = 1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_window = w;
    cmd_valid = 1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("cmd_ready_timeout", 0, 1);
    hs_edge = cyc + 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("load_ctrl", la_ctrl_out, 32'h2);
    chk("load_a", la_a_out, a);
    chk("load_b", la_b_out, b);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic push(input logic [31:0] s,
                      input logic [31:0] c,
                      input logic er, input logic ab,
                      input int lat);
    exp_t x;
    x.sum = s; x.cnt = c; x.err = er;
    x.abt = ab; x.lat = lat;
    q.push_back(x);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_ctrl", la_ctrl_out, 0);
    chk("rst_oenb", la_oenb_out, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("first_ready", {31'b0, cmd_ready}, 1);

    // basic
    la_sum_in = 8; la_count_in = 32'h20;
    push(8, 32'h20, 0, 0, 8);
    run_hi = 0;
    send(3, 5, 4);
    drain();
    chk("run_cycles_w4", run_hi, 4);
    chk("hold_a", la_a_out, 3);
    chk("hold_b", la_b_out, 5);
    chk("oenb", la_oenb_out, 0);

    // wrap with wrong and right sum
    la_sum_in = 1; la_count_in = 9;
    push(1, 9, 1, 0, 6);
    send(32'hFFFF_FFFF, 1, 2);
    drain();
    la_sum_in = 0;
    push(0, 9, 0, 0, 6);
    send(32'hFFFF_FFFF, 1, 2);
    drain();

    // window zero behaves as one
    la_sum_in = 32'h30; la_count_in = 3;
    push(32'h30, 3, 0, 0, 5);
    run_hi = 0;
    send(32'h10, 32'h20, 0);
    drain();
    chk("run_cycles_w0", run_hi, 1);

    // abort during run
    la_sum_in = 32'h55; la_count_in = 32'h66;
    push(0, 0, 0, 1, 0);
    send(7, 8, 10);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_run", la_ctrl_out, 1);
    active = 0;
    @(negedge clk);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("abort_run_low", la_ctrl_out, 0);
    drain();
    @(negedge clk);
    chk("inactive_not_ready", {31'b0, cmd_ready}, 0);
    active = 1;
    #1;
    chk("active_ready", {31'b0, cmd_ready}, 1);

    // backpressure
    rsp_ready = 0;
    la_sum_in = 30; la_count_in = 7;
    push(30, 7, 0, 0, 5);
    send(10, 20, 1);
    for (int i = 0; i < 20 && !rsp_valid; i++)
      @(negedge clk);
    chk("bp_valid", {31'b0, rsp_valid}, 1);
    la_sum_in = 32'hDEAD; la_count_in = 32'hBEEF;
    cmd_a = 99; cmd_b = 98; cmd_window = 3;
    cmd_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 0);
      chk("bp_hold", {31'b0, rsp_valid}, 1);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    drain();
    chk("bp_a_kept", la_a_out, 10);

    // reset during run
    send(1, 2, 20);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_run", la_ctrl_out, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_ctrl", la_ctrl_out, 0);
    chk("mid_rst_a", la_a_out, 0);
    chk("mid_rst_b", la_b_out, 0);
    chk("mid_rst_valid", {31'b0, rsp_valid}, 0);
    chk("mid_rst_ready", {31'b0, cmd_ready}, 0);
    chk("mid_rst_sum", rsp_sum, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, cmd_ready}, 1);
    chk("post_rst_ctrl", la_ctrl_out, 0);
    chk("post_rst_q", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
